// File: rtl/fetch_unit_pkg.sv
// Shared CPU defines for the PC, fetch and decode stages, plus the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int MEM_SIZE    = 8;
    localparam int OFFSET_SIZE = 4;
    localparam int WAIT_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_wdt.sv
// Wait-state watchdog for the fetch stage.
// It counts cycles in which memory has not answered, and saturates at the all-ones value.
module fetch_wdt
    import fetch_unit_pkg::*;
#(
    parameter int wait_width = WAIT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [wait_width-1:0] MAX_WAIT = '1;

    logic [wait_width-1:0] wait_cnt;

    // The counter restarts on every new fetch or flush, and advances only while a fetch is unanswered.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wait_cnt <= '0;
        end else if (enable && (wait_cnt != MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expired = (wait_cnt == MAX_WAIT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: runs the memory read handshake, fills the IR and pulses the PC offset.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int word_size   = WORD_SIZE,
    parameter int mem_size    = MEM_SIZE,
    parameter int offset_size = OFFSET_SIZE,
    parameter int wait_width  = WAIT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [word_size-1:0]   pc_counter,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   mem_rd,
    output logic [mem_size-1:0]    mem_addr,
    input  logic                   mem_rdy,
    input  logic [word_size-1:0]   mem_data,
    output logic [word_size-1:0]   ir,
    output logic [mem_size-1:0]    ir_pc,
    output logic                   ir_valid,
    input  logic                   ir_ack,
    output logic [offset_size-1:0] offset,
    output logic                   fetch_err
);

    fetch_state_t state, state_next;

    logic                   mem_rd_next;
    logic [mem_size-1:0]    mem_addr_next;
    logic [word_size-1:0]   ir_next;
    logic [mem_size-1:0]    ir_pc_next;
    logic                   ir_valid_next;
    logic [offset_size-1:0] offset_next;
    logic                   fetch_err_next;
    logic                   wdt_clear;
    logic                   wdt_enable;
    logic                   wdt_expired;

    logic unused_pc_hi;
    assign unused_pc_hi = ^pc_counter[word_size-1:mem_size];

    fetch_wdt #(
        .wait_width (wait_width)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clear   (wdt_clear),
        .enable  (wdt_enable),
        .expired (wdt_expired)
    );

    // State and all outputs are registered; reset returns everything to an empty idle stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            ir        <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            offset    <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_next;
            mem_rd    <= mem_rd_next;
            mem_addr  <= mem_addr_next;
            ir        <= ir_next;
            ir_pc     <= ir_pc_next;
            ir_valid  <= ir_valid_next;
            offset    <= offset_next;
            fetch_err <= fetch_err_next;
        end
    end

    // Next-state logic: flush overrides everything except ERROR, and offset falls back to 0 by default.
    always_comb begin
        state_next     = state;
        mem_rd_next    = mem_rd;
        mem_addr_next  = mem_addr;
        ir_next        = ir;
        ir_pc_next     = ir_pc;
        ir_valid_next  = ir_valid;
        offset_next    = '0;
        fetch_err_next = fetch_err;
        wdt_clear      = 1'b0;
        wdt_enable     = 1'b0;

        if (flush && (state != ST_ERROR)) begin
            ir_valid_next = 1'b0;
            mem_rd_next   = 1'b0;
            wdt_clear     = 1'b1;
            state_next    = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!stall) begin
                        mem_addr_next = pc_counter[mem_size-1:0];
                        mem_rd_next   = 1'b1;
                        wdt_clear     = 1'b1;
                        state_next    = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_rdy) begin
                        ir_next       = mem_data;
                        ir_pc_next    = mem_addr;
                        ir_valid_next = 1'b1;
                        offset_next   = offset_size'(1);
                        mem_rd_next   = 1'b0;
                        state_next    = ST_FULL;
                    end else if (!wdt_expired) begin
                        wdt_enable = 1'b1;
                    end else begin
                        fetch_err_next = 1'b1;
                        mem_rd_next    = 1'b0;
                        state_next     = ST_ERROR;
                    end
                end
                ST_FULL: begin
                    if (ir_ack) begin
                        ir_valid_next = 1'b0;
                        state_next    = ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    mem_rd_next = 1'b0;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: a vector table plus hand-written multi-cycle sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] pc_counter;
    logic        stall;
    logic        flush;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic        mem_rdy;
    logic [15:0] mem_data;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ack;
    logic [3:0]  offset;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [15:0] pc;
        logic        stall;
        logic        flush;
        logic        rdy;
        logic [15:0] data;
        logic        ack;
        logic        e_rd;
        logic [7:0]  e_addr;
        logic [15:0] e_ir;
        logic [7:0]  e_irpc;
        logic        e_valid;
        logic [3:0]  e_off;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pc_counter (pc_counter),
        .stall      (stall),
        .flush      (flush),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdy    (mem_rdy),
        .mem_data   (mem_data),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ack     (ir_ack),
        .offset     (offset),
        .fetch_err  (fetch_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic r, logic [15:0] pc, logic st, logic fl, logic rdy,
                                logic [15:0] data, logic ack, logic e_rd, logic [7:0] e_addr,
                                logic [15:0] e_ir, logic [7:0] e_irpc, logic e_valid,
                                logic [3:0] e_off, logic e_err);
        vec_t v;
        v.rst = r; v.pc = pc; v.stall = st; v.flush = fl; v.rdy = rdy; v.data = data; v.ack = ack;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_ir = e_ir; v.e_irpc = e_irpc;
        v.e_valid = e_valid; v.e_off = e_off; v.e_err = e_err;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst        = v.rst;
        pc_counter = v.pc;
        stall      = v.stall;
        flush      = v.flush;
        mem_rdy    = v.rdy;
        mem_data   = v.data;
        ir_ack     = v.ack;
    endtask

    task automatic doReset(input logic [15:0] pc);
        applyStimulus(mk(1'b1, pc, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int rd_cnt;
        int off_cnt;
        int i;
        logic [15:0] pc_model;
        logic        prev_rd;
        int          nstarts;
        logic [7:0]  start_addr [8];
        int          start_cyc  [8];

        applyStimulus(mk(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0, 0, 0, 0, 0, 0, 0));

        // rst pc stall flush rdy data ack | rd addr ir irpc valid off err
        vecs.push_back(mk(1, 16'h0005, 0, 0, 0, 16'h0000, 0,  0, 8'h00, 16'h0000, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0005, 0, 0, 0, 16'h0000, 0,  1, 8'h05, 16'h0000, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0005, 0, 0, 1, 16'hA1B2, 0,  0, 8'h05, 16'hA1B2, 8'h05, 1, 1, 0));
        vecs.push_back(mk(0, 16'h0006, 0, 0, 0, 16'h0000, 0,  0, 8'h05, 16'hA1B2, 8'h05, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0006, 0, 0, 0, 16'h0000, 1,  0, 8'h05, 16'hA1B2, 8'h05, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 16'h0006, 1, 0, 0, 16'h0000, 0,  0, 8'h05, 16'hA1B2, 8'h05, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0106, 0, 0, 0, 16'h0000, 0,  1, 8'h06, 16'hA1B2, 8'h05, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0106, 0, 1, 1, 16'hBEEF, 0,  0, 8'h06, 16'hA1B2, 8'h05, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0040, 0, 0, 0, 16'h0000, 0,  1, 8'h40, 16'hA1B2, 8'h05, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0040, 0, 0, 1, 16'h1234, 0,  0, 8'h40, 16'h1234, 8'h40, 1, 1, 0));
        vecs.push_back(mk(0, 16'h0041, 1, 0, 0, 16'h0000, 0,  0, 8'h40, 16'h1234, 8'h40, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0041, 0, 0, 0, 16'h0000, 0,  0, 8'h40, 16'h1234, 8'h40, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0041, 0, 0, 1, 16'hFFFF, 0,  0, 8'h40, 16'h1234, 8'h40, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0041, 0, 0, 0, 16'h0000, 1,  0, 8'h40, 16'h1234, 8'h40, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0041, 0, 1, 0, 16'h0000, 0,  0, 8'h40, 16'h1234, 8'h40, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0041, 0, 0, 0, 16'h0000, 0,  1, 8'h41, 16'h1234, 8'h40, 0, 0, 0));

        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n]);
            tick();
            checkOutput($sformatf("v%0d mem_rd", n),    16'(mem_rd),    16'(vecs[n].e_rd));
            checkOutput($sformatf("v%0d mem_addr", n),  16'(mem_addr),  16'(vecs[n].e_addr));
            checkOutput($sformatf("v%0d ir", n),        ir,             vecs[n].e_ir);
            checkOutput($sformatf("v%0d ir_pc", n),     16'(ir_pc),     16'(vecs[n].e_irpc));
            checkOutput($sformatf("v%0d ir_valid", n),  16'(ir_valid),  16'(vecs[n].e_valid));
            checkOutput($sformatf("v%0d offset", n),    16'(offset),    16'(vecs[n].e_off));
            checkOutput($sformatf("v%0d fetch_err", n), 16'(fetch_err), 16'(vecs[n].e_err));
        end

        // Three wait states before memory answers.
        doReset(16'h0022);
        tick();
        rd_cnt = mem_rd ? 1 : 0;
        checkOutput("ws start addr", 16'(mem_addr), 16'h0022);
        pc_counter = 16'h0099;
        for (int k = 0; k < 3; k++) begin
            mem_rdy = 1'b0;
            tick();
            if (mem_rd) rd_cnt++;
            checkOutput("ws addr stable", 16'(mem_addr), 16'h0022);
            checkOutput("ws no err", 16'(fetch_err), 16'h0000);
        end
        mem_rdy  = 1'b1;
        mem_data = 16'h5A5A;
        tick();
        checkOutput("ws ir", ir, 16'h5A5A);
        checkOutput("ws ir_pc", 16'(ir_pc), 16'h0022);
        checkOutput("ws offset", 16'(offset), 16'h0001);
        checkOutput("ws rd dropped", 16'(mem_rd), 16'h0000);
        mem_rdy = 1'b0;
        tick();
        checkOutput("ws offset cleared", 16'(offset), 16'h0000);
        checkOutput("ws rd cycles", 16'(rd_cnt), 16'd4);

        // Memory never answers: watchdog must trip after 16 read cycles.
        doReset(16'h0033);
        tick();
        rd_cnt = mem_rd ? 1 : 0;
        i = 0;
        while (i < 20 && !fetch_err) begin
            tick();
            if (mem_rd) rd_cnt++;
            i++;
        end
        checkOutput("wd err set", 16'(fetch_err), 16'h0001);
        checkOutput("wd rd cycles", 16'(rd_cnt), 16'd16);
        checkOutput("wd rd low", 16'(mem_rd), 16'h0000);
        flush   = 1'b1;
        ir_ack  = 1'b1;
        mem_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("err sticky", 16'(fetch_err), 16'h0001);
            checkOutput("err rd", 16'(mem_rd), 16'h0000);
            checkOutput("err valid", 16'(ir_valid), 16'h0000);
            checkOutput("err offset", 16'(offset), 16'h0000);
        end
        doReset(16'h0000);
        checkOutput("err cleared", 16'(fetch_err), 16'h0000);

        // Four back-to-back fetches with a PC model driven by the offset pulse.
        pc_model = 16'h0000;
        prev_rd  = 1'b0;
        nstarts  = 0;
        off_cnt  = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            pc_counter = pc_model;
            mem_rdy    = mem_rd;
            ir_ack     = ir_valid;
            tick();
            if (mem_rd && !prev_rd && nstarts < 8) begin
                start_addr[nstarts] = mem_addr;
                start_cyc[nstarts]  = cyc;
                nstarts++;
            end
            prev_rd = mem_rd;
            if (offset != 4'h0) begin
                off_cnt++;
                pc_model = pc_model + 16'(offset);
            end
        end
        checkOutput("loop starts", 16'(nstarts), 16'd4);
        checkOutput("loop offsets", 16'(off_cnt), 16'd4);
        for (int k = 0; k < 4 && k < nstarts; k++) begin
            checkOutput($sformatf("loop addr%0d", k), 16'(start_addr[k]), 16'(k));
            if (k > 0)
                checkOutput($sformatf("loop gap%0d", k), 16'(start_cyc[k] - start_cyc[k-1]), 16'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly downstream of the program counter: it reads the current PC, runs a read handshake with instruction memory, and latches the returned word into the instruction register for decode. On each accepted fetch it issues a one-cycle offset pulse back to the PC's offset input. It also runs a wait-state watchdog and supports flush on control transfers.

## Interface
- word_size, 16, instruction/data word width (matches PC)
- mem_size, 8, instruction memory address width
- offset_size, 4, width of the PC offset return path
- wait_width, 4, watchdog counter width; max_wait = 2**wait_width-1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_counter  in  word_size  current PC value
- stall  in  1  inhibits starting a new fetch
- flush  in  1  aborts in-flight fetch, discards IR
- mem_rd  out  1  memory read request, registered
- mem_addr  out  mem_size  fetch address, registered
- mem_rdy  in  1  memory data valid this cycle
- mem_data  in  word_size  memory read data
- ir  out  word_size  instruction register
- ir_pc  out  mem_size  address the IR word came from
- ir_valid  out  1  IR holds an unconsumed instruction
- ir_ack  in  1  decode consumes IR this cycle
- offset  out  offset_size  PC increment pulse (1 for one cycle, else 0)
- fetch_err  out  1  watchdog expired; sticky until rst

## Operation
- Reset (rst=1 at an edge): state IDLE; mem_rd=0, mem_addr=0, ir=0, ir_pc=0, ir_valid=0, offset=0, fetch_err=0, wait_cnt=0.
- States: IDLE, FETCH, FULL, ERROR.
- IDLE: if !stall && !flush -> FETCH; at that edge mem_addr <= pc_counter[mem_size-1:0], mem_rd <= 1, wait_cnt <= 0.
- FETCH: mem_rd held high and mem_addr held stable; stall ignored.
  - mem_rdy=1: ir <= mem_data, ir_pc <= mem_addr, ir_valid <= 1, offset <= 1, mem_rd <= 0 -> FULL.
  - mem_rdy=0, wait_cnt<max_wait: wait_cnt <= wait_cnt+1.
  - mem_rdy=0, wait_cnt==max_wait: fetch_err <= 1, mem_rd <= 0 -> ERROR.
- FULL: offset returns to 0 after one cycle; ir held. ir_ack=1 -> ir_valid <= 0 -> IDLE.
- ERROR: all outputs frozen except mem_rd=0; leaves only on rst; flush ignored.
- flush (priority below rst, above everything else; no effect in ERROR): ir_valid <= 0, mem_rd <= 0, offset <= 0, wait_cnt <= 0 -> IDLE. mem_rdy coinciding with flush is discarded; no offset pulse issued.
- mem_rdy outside FETCH ignored; ir_ack outside FULL ignored.
- Address = low mem_size bits of pc_counter; upper bits ignored. wait_cnt never wraps.

## Timing
- FETCH entered at edge E0: mem_rd/mem_addr valid in cycle following E0 (cycle N).
- mem_rdy high in cycle N -> ir/ir_valid/offset=1 in cycle N+1; PC updates at end of N+1.
- Earliest ir_ack is cycle N+1 -> IDLE in N+2 -> new address latched at end of N+2, already seeing updated PC. Back-to-back throughput: one instruction per 3 cycles with zero wait states.
- Maximum mem_rd duration: max_wait+1 cycles; error visible the cycle after the last.
- offset is nonzero in exactly one cycle per accepted fetch.

## Structure
- State encoding localparams, word_size/mem_size/offset_size defaults: shared CPU defines package so the PC, fetch and decode stages agree.
- One sub-module: fetch_wdt (wait counter, clear/enable inputs, expired output).

## Test plan
- rst, pc_counter=0x0005, mem_rdy next cycle with mem_data=0xA1B2 -> mem_addr=0x05, ir=0xA1B2, ir_pc=0x05, offset=1 for exactly one cycle.
- 3 wait states before mem_rdy -> mem_rd high 4 cycles, mem_addr stable, one capture, no fetch_err.
- mem_rdy never asserted -> mem_rd high 16 cycles, fetch_err=1, state ERROR; flush and ir_ack ignored until rst.
- flush in the same cycle as mem_rdy -> ir_valid stays 0, offset stays 0, next fetch starts from new pc_counter.
- stall held high in IDLE for 5 cycles -> mem_rd stays 0; release -> fetch begins next edge; ir_ack withheld -> ir held, no new fetch.
- Loop of 4 fetches with PC model, ack immediately -> addresses 0,1,2,3 in order, 3-cycle spacing, no skipped or repeated address.
